// File: rtl/if_fetch_queue_if.sv
// Bus, redirect and decode handshake bundle for the instruction fetch queue.
interface if_fetch_queue_if;
  logic        fetch_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        fs_to_ds_adel;

  // Environment side: drives control, bus responses and decode back-pressure.
  modport master (
    output fetch_stall, redirect_valid, redirect_pc,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output ds_allowin,
    input  inst_sram_req, inst_sram_addr,
    input  fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_adel
  );

  // Fetch queue side.
  modport slave (
    input  fetch_stall, redirect_valid, redirect_pc,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  ds_allowin,
    output inst_sram_req, inst_sram_addr,
    output fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_adel
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues in-order fetch requests, tracks the PCs of
// accepted requests, drops responses belonging to flushed requests, and
// buffers returned instructions for decode.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH      = 4
) (
  input  logic           clk,
  input  logic           reset,
  if_fetch_queue_if.slave bus
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DW = $clog2(2 * MAX_OUTSTANDING + 1);
  localparam int unsigned BW = $clog2(IBUF_DEPTH);
  localparam int unsigned CW = $clog2(IBUF_DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic          r_halted;

  logic [31:0]   r_pend_pc [MAX_OUTSTANDING];
  logic [PW-1:0] r_pend_rd;
  logic [PW-1:0] r_pend_wr;
  logic [OW-1:0] r_pend_cnt;

  logic [DW-1:0] r_disc_cnt;

  logic [31:0]   r_buf_pc   [IBUF_DEPTH];
  logic [31:0]   r_buf_inst [IBUF_DEPTH];
  logic          r_buf_adel [IBUF_DEPTH];
  logic [BW-1:0] r_buf_rd;
  logic [BW-1:0] r_buf_wr;
  logic [CW-1:0] r_buf_cnt;

  logic          w_aligned;
  logic          w_fetch_ok;
  logic          w_room;
  logic          w_req;
  logic          w_accept;
  logic          w_adel_wr;
  logic          w_data_live;
  logic          w_buf_wr;
  logic          w_buf_rd;
  logic          w_head_valid;
  logic [31:0]   w_wr_pc;
  logic [31:0]   w_wr_inst;

  // Pending FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] f_pend_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Issue/admit decisions. Buffer slots are reserved for every live request,
  // so a returning instruction always finds room; discarded responses never
  // occupy the buffer and therefore do not count against it.
  always_comb begin
    w_aligned    = (r_fetch_pc[1:0] == 2'b00);
    w_fetch_ok   = ~reset & ~bus.fetch_stall & ~bus.redirect_valid & ~r_halted;
    w_room       = (32'(r_pend_cnt) + 32'(r_buf_cnt)) < IBUF_DEPTH;
    w_req        = w_fetch_ok & w_aligned & (32'(r_pend_cnt) < MAX_OUTSTANDING) & w_room;
    w_accept     = w_req & bus.inst_sram_addr_ok;
    // Misaligned PC: only once nothing is in flight, so the error entry stays in order.
    w_adel_wr    = w_fetch_ok & ~w_aligned & (r_pend_cnt == '0) & w_room;
    w_data_live  = bus.inst_sram_data_ok & (r_disc_cnt == '0);
    w_buf_wr     = (w_data_live & ~bus.redirect_valid) | w_adel_wr;
    w_head_valid = (r_buf_cnt != '0);
    w_buf_rd     = w_head_valid & bus.ds_allowin;
    w_wr_pc      = w_adel_wr ? r_fetch_pc : r_pend_pc[r_pend_rd];
    w_wr_inst    = w_adel_wr ? '0 : bus.inst_sram_rdata;
  end

  assign bus.inst_sram_req  = w_req;
  assign bus.inst_sram_addr = r_fetch_pc;
  assign bus.fs_to_ds_valid = w_head_valid;
  assign bus.fs_to_ds_pc    = w_head_valid ? r_buf_pc[r_buf_rd]   : '0;
  assign bus.fs_to_ds_inst  = w_head_valid ? r_buf_inst[r_buf_rd] : '0;
  assign bus.fs_to_ds_adel  = w_head_valid ? r_buf_adel[r_buf_rd] : 1'b0;

  // Fetch PC and the halt-after-address-error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_halted   <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= bus.redirect_pc;
      r_halted   <= 1'b0;
    end else begin
      if (w_accept)  r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_adel_wr) r_halted   <= 1'b1;
    end
  end

  // Pending-PC FIFO control: push on accept, pop on a live response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_rd  <= '0;
      r_pend_wr  <= '0;
      r_pend_cnt <= '0;
    end else if (bus.redirect_valid) begin
      r_pend_rd  <= '0;
      r_pend_wr  <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_accept)    r_pend_wr <= f_pend_next(r_pend_wr);
      if (w_data_live) r_pend_rd <= f_pend_next(r_pend_rd);
      case ({w_accept, w_data_live})
        2'b10:   r_pend_cnt <= r_pend_cnt + OW'(1);
        2'b01:   r_pend_cnt <= r_pend_cnt - OW'(1);
        default: r_pend_cnt <= r_pend_cnt;
      endcase
    end
  end

  // Pending-PC storage.
  always_ff @(posedge clk) begin
    if (w_accept) r_pend_pc[r_pend_wr] <= r_fetch_pc;
  end

  // Discard counter: responses still owed to flushed requests. A response
  // arriving in the redirect cycle settles one of them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disc_cnt <= '0;
    end else if (bus.redirect_valid) begin
      r_disc_cnt <= r_disc_cnt + DW'(r_pend_cnt) - DW'(bus.inst_sram_data_ok);
    end else if (bus.inst_sram_data_ok && r_disc_cnt != '0) begin
      r_disc_cnt <= r_disc_cnt - DW'(1);
    end
  end

  // Instruction buffer control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_rd  <= '0;
      r_buf_wr  <= '0;
      r_buf_cnt <= '0;
    end else if (bus.redirect_valid) begin
      r_buf_rd  <= '0;
      r_buf_wr  <= '0;
      r_buf_cnt <= '0;
    end else begin
      if (w_buf_wr) r_buf_wr <= r_buf_wr + BW'(1);
      if (w_buf_rd) r_buf_rd <= r_buf_rd + BW'(1);
      case ({w_buf_wr, w_buf_rd})
        2'b10:   r_buf_cnt <= r_buf_cnt + CW'(1);
        2'b01:   r_buf_cnt <= r_buf_cnt - CW'(1);
        default: r_buf_cnt <= r_buf_cnt;
      endcase
    end
  end

  // Instruction buffer storage.
  always_ff @(posedge clk) begin
    if (w_buf_wr) begin
      r_buf_pc[r_buf_wr]   <= w_wr_pc;
      r_buf_inst[r_buf_wr] <= w_wr_inst;
      r_buf_adel[r_buf_wr] <= w_adel_wr;
    end
  end

  a_no_spurious_data_ok: assert property (
    @(posedge clk) disable iff (reset)
      !(bus.inst_sram_data_ok && r_pend_cnt == '0 && r_disc_cnt == '0)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed vector table, hand-written redirect and
// address-error sequences, and randomized traffic against a queue-based model.
module tb_if_fetch_queue;

  localparam logic [31:0] RPC = 32'hbfc00000;

  logic clk = 1'b0;
  logic reset;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  if_fetch_queue_if bus ();

  if_fetch_queue #(
    .RESET_PC       (RPC),
    .MAX_OUTSTANDING(2),
    .IBUF_DEPTH     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Model: every accepted bus request in order, tagged live or flushed.
  typedef struct { logic [31:0] pc; logic live; } bus_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adel; } ent_t;
  bus_t        bus_q[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc;
  logic        m_halted;

  logic        s_req, s_valid, s_adel;
  logic [31:0] s_addr, s_pc, s_inst;

  typedef struct {
    logic aok; logic dok; logic al;
    logic ereq; logic [31:0] eaddr; logic ev; logic [31:0] epc;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5a3c96e1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rp,
                       input logic aok, input logic dok, input logic al);
    bus.fetch_stall       = st;
    bus.redirect_valid    = rv;
    bus.redirect_pc       = rp;
    bus.inst_sram_addr_ok = aok;
    bus.inst_sram_data_ok = dok;
    bus.ds_allowin        = al;
  endtask

  task automatic model_reset();
    m_pc     = RPC;
    m_halted = 1'b0;
    bus_q.delete();
    m_buf.delete();
  endtask

  // One clock: compare outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int   lc;
    logic m_req, m_adel;
    bus_t b;
    if (bus_q.size() == 0) bus.inst_sram_data_ok = 1'b0;
    if (bus.inst_sram_data_ok) bus.inst_sram_rdata = mem_word(bus_q[0].pc);
    else                       bus.inst_sram_rdata = $urandom;
    lc = 0;
    for (int i = 0; i < bus_q.size(); i++) if (bus_q[i].live) lc++;
    m_req  = !bus.fetch_stall && !bus.redirect_valid && !m_halted &&
             lc < 2 && (lc + m_buf.size()) < 4 && m_pc[1:0] == 2'b00;
    m_adel = !bus.fetch_stall && !bus.redirect_valid && !m_halted &&
             m_pc[1:0] != 2'b00 && lc == 0 && m_buf.size() < 4;
    @(negedge clk);
    s_req   = bus.inst_sram_req;
    s_addr  = bus.inst_sram_addr;
    s_valid = bus.fs_to_ds_valid;
    s_pc    = bus.fs_to_ds_pc;
    s_inst  = bus.fs_to_ds_inst;
    s_adel  = bus.fs_to_ds_adel;
    chk("model_req", 32'(s_req), 32'(m_req));
    if (m_req) chk("model_addr", s_addr, m_pc);
    chk("model_valid", 32'(s_valid), 32'(m_buf.size() != 0));
    if (m_buf.size() != 0) begin
      chk("model_head_pc", s_pc, m_buf[0].pc);
      chk("model_head_inst", s_inst, m_buf[0].inst);
      chk("model_head_adel", 32'(s_adel), 32'(m_buf[0].adel));
    end
    @(posedge clk);
    if (bus.redirect_valid) begin
      for (int i = 0; i < bus_q.size(); i++) bus_q[i].live = 1'b0;
      if (bus.inst_sram_data_ok) void'(bus_q.pop_front());
      m_buf.delete();
      m_pc     = bus.redirect_pc;
      m_halted = 1'b0;
    end else begin
      if (m_buf.size() != 0 && bus.ds_allowin) void'(m_buf.pop_front());
      if (bus.inst_sram_data_ok) begin
        b = bus_q.pop_front();
        if (b.live) m_buf.push_back(ent_t'{b.pc, mem_word(b.pc), 1'b0});
      end
      if (m_req && bus.inst_sram_addr_ok) begin
        bus_q.push_back(bus_t'{m_pc, 1'b1});
        m_pc = m_pc + 32'd4;
      end
      if (m_adel) begin
        m_buf.push_back(ent_t'{m_pc, 32'h0, 1'b1});
        m_halted = 1'b1;
      end
    end
    #1;
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_req", 32'(bus.inst_sram_req), 32'h0);
    chk("rst_valid", 32'(bus.fs_to_ds_valid), 32'h0);
    chk("rst_pc", bus.fs_to_ds_pc, 32'h0);
    chk("rst_inst", bus.fs_to_ds_inst, 32'h0);
    chk("rst_adel", 32'(bus.fs_to_ds_adel), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_req", 32'(bus.inst_sram_req), 32'h0);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nvalid;
    logic        st, rv, aok, dok, al;
    logic [31:0] rp;

    //            aok   dok   al    ereq  eaddr         ev    epc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, RPC + 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, RPC + 32'h04, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, RPC + 32'h08, 1'b1, RPC};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, RPC};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, RPC + 32'h0c, 1'b1, RPC};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, RPC};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, RPC};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, RPC};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, RPC + 32'h10, 1'b1, RPC + 32'h04};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, RPC + 32'h04};

    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    bus.inst_sram_rdata = 32'h0;
    model_reset();

    // Outstanding limit, buffer-full back-pressure, single-slot release.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 32'h0, tbl[i].aok, tbl[i].dok, tbl[i].al);
      cycle();
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].ereq));
      if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_inst", i), s_inst, mem_word(tbl[i].epc));
      end
    end

    // Streaming: one-cycle response, decode always ready, no bubbles.
    do_reset();
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      cycle();
      if (i >= 2) chk("steady_pc", s_pc, RPC + 32'(4 * (i - 2)));
      if (i >= 4 && s_valid) nvalid++;
    end
    chk("steady_no_bubble", nvalid, 32'd16);

    // Redirect with bfc00008/bfc0000c in flight: both responses are dropped.
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0); cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0); cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); cycle();
    chk("flush_pre_addr", s_addr, RPC + 32'h0c);
    drive(1'b0, 1'b1, 32'hbfc00380, 1'b1, 1'b0, 1'b0); cycle();
    chk("flush_redirect_req", 32'(s_req), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0); cycle();
    chk("flush_first_req", 32'(s_req), 32'h1);
    chk("flush_first_addr", s_addr, 32'hbfc00380);
    chk("flush_stale0", 32'(s_valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); cycle();
    chk("flush_stale1", 32'(s_valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); cycle();
    chk("flush_stale2", 32'(s_valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0); cycle();
    chk("flush_head_valid", 32'(s_valid), 32'h1);
    chk("flush_head_pc", s_pc, 32'hbfc00380);

    // Redirect coinciding with the only outstanding response.
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1); cycle();
    drive(1'b0, 1'b1, 32'h00001000, 1'b0, 1'b1, 1'b1); cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1); cycle();
    chk("coinc_stale0", 32'(s_valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1); cycle();
    chk("coinc_stale1", 32'(s_valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); cycle();
    chk("coinc_addr", s_addr, 32'h00001000);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0); cycle();
    chk("coinc_head_pc", s_pc, 32'h00001000);

    // Misaligned redirect: error entry, no bus traffic until the next redirect.
    drive(1'b0, 1'b1, 32'h80000002, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); cycle();
    chk("adel_req_c1", 32'(s_req), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); cycle();
    chk("adel_valid", 32'(s_valid), 32'h1);
    chk("adel_pc", s_pc, 32'h80000002);
    chk("adel_inst", s_inst, 32'h0);
    chk("adel_flag", 32'(s_adel), 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1); cycle();
      chk("adel_halt_req", 32'(s_req), 32'h0);
      chk("adel_halt_valid", 32'(s_valid), 32'h0);
    end
    drive(1'b0, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1); cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1); cycle();
    chk("adel_resume_req", 32'(s_req), 32'h1);
    chk("adel_resume_addr", s_addr, 32'h80000000);

    // Randomized traffic, including a mid-run reset and PC wrap-around.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      st  = ($urandom_range(0, 7) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 7))
        0:       rp = 32'h90000000 + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(1, 3));
        1:       rp = 32'hfffffff8;
        default: rp = 32'h90000000 + 32'($urandom_range(0, 63) << 2);
      endcase
      aok = (bus_q.size() < 4) && ($urandom_range(0, 3) != 0);
      dok = ($urandom_range(0, 2) != 0);
      al  = ($urandom_range(0, 3) != 0);
      drive(st, rv, rp, aok, dok, al);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
